// File: rtl/mf_clkgen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mf_clkgen_pkg
// Description : Shared definitions for the multi-channel fractional clock
//               generator: config register addresses, the per-channel config
//               record and a helper that applies one register write to it.
// Revision    : 1.0 - initial release
// ============================================================================
package mf_clkgen_pkg;

    // Register select values on cfg_addr (3 is reserved, writes ignored)
    localparam logic [1:0] CFG_NUM   = 2'd0;
    localparam logic [1:0] CFG_DEN   = 2'd1;
    localparam logic [1:0] CFG_PHASE = 2'd2;

    // Widest accumulator supported; narrower instances zero-extend into it
    localparam int CLKGEN_MAX_W = 64;

    typedef logic [CLKGEN_MAX_W-1:0] cfg_word_t;

    typedef struct packed {
        cfg_word_t num;
        cfg_word_t den;
        cfg_word_t phase;
    } ch_cfg_t;

    // Returns the config record with one register replaced; the reserved
    // address leaves the record untouched.
    function automatic ch_cfg_t cfg_update(input ch_cfg_t   cur,
                                           input logic [1:0] addr,
                                           input cfg_word_t data);
        ch_cfg_t nxt;
        nxt = cur;
        case (addr)
            CFG_NUM:   nxt.num   = data;
            CFG_DEN:   nxt.den   = data;
            CFG_PHASE: nxt.phase = data;
            default:   nxt       = cur;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mf_clkgen_ch.sv
`default_nettype none
// ============================================================================
// Module      : mf_clkgen_ch
// Description : One fractional clock channel. Holds the active num/den/phase,
//               a phase accumulator, and registered ce/clk outputs.
// Ports       : refclk, rst_n    - clock, async active-low reset
//               apply            - copy shadow_cfg to active and re-align
//               run_rise         - re-align using the active config
//               run              - accumulate while high
//               shadow_cfg       - shadow config from the top level
//               ce_o / clk_o     - enable pulse / square wave
//               invalid          - enabled (den!=0) but num is unusable
// Revision    : 1.0 - initial release
// ============================================================================
module mf_clkgen_ch
    import mf_clkgen_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic    refclk,
    input  logic    rst_n,
    input  logic    apply,
    input  logic    run_rise,
    input  logic    run,
    input  ch_cfg_t shadow_cfg,
    output logic    ce_o,
    output logic    clk_o,
    output logic    invalid
);

    logic [ACC_W-1:0] r_num;
    logic [ACC_W-1:0] r_den;
    logic [ACC_W-1:0] r_phase;
    logic [ACC_W-1:0] r_acc;
    logic             r_ce;
    logic             r_clk;

    logic [ACC_W-1:0] w_sh_num;
    logic [ACC_W-1:0] w_sh_den;
    logic [ACC_W-1:0] w_sh_phase;
    logic [ACC_W-1:0] w_ld_den;
    logic [ACC_W-1:0] w_ld_phase;
    logic [ACC_W-1:0] w_init;
    logic [ACC_W:0]   w_sum;
    logic             w_wrap;
    logic             w_enabled;
    logic             w_valid;

    assign w_sh_num   = shadow_cfg.num[ACC_W-1:0];
    assign w_sh_den   = shadow_cfg.den[ACC_W-1:0];
    assign w_sh_phase = shadow_cfg.phase[ACC_W-1:0];

    // Shadow words are zero-extended copies of ACC_W-bit data, so the upper
    // bits carry no information here.
    generate
        if (ACC_W < CLKGEN_MAX_W) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = |{shadow_cfg.num[CLKGEN_MAX_W-1:ACC_W],
                                   shadow_cfg.den[CLKGEN_MAX_W-1:ACC_W],
                                   shadow_cfg.phase[CLKGEN_MAX_W-1:ACC_W]};
        end
    endgenerate

    // Re-alignment start value comes from the config that will be active
    // after this edge: the shadow on apply, otherwise the current active set.
    assign w_ld_den   = apply ? w_sh_den   : r_den;
    assign w_ld_phase = apply ? w_sh_phase : r_phase;
    assign w_init     = (w_ld_phase < w_ld_den) ? w_ld_phase : '0;

    assign w_enabled  = (r_den != '0);
    assign w_valid    = w_enabled && (r_num != '0) && (r_num < r_den);
    assign invalid    = w_enabled && !w_valid;

    // One extra bit so acc+num never overflows before the den compare
    assign w_sum  = {1'b0, r_acc} + {1'b0, r_num};
    assign w_wrap = (w_sum >= {1'b0, r_den});

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_num   <= '0;
            r_den   <= '0;
            r_phase <= '0;
            r_acc   <= '0;
            r_ce    <= 1'b0;
            r_clk   <= 1'b0;
        end else begin
            if (apply) begin
                r_num   <= w_sh_num;
                r_den   <= w_sh_den;
                r_phase <= w_sh_phase;
            end
            if (apply || run_rise) begin
                r_acc <= w_init;
                r_ce  <= 1'b0;
                r_clk <= 1'b0;
            end else if (run && w_valid) begin
                r_acc <= w_wrap ? ACC_W'(w_sum - {1'b0, r_den}) : ACC_W'(w_sum);
                r_ce  <= w_wrap;
                r_clk <= r_clk ^ w_wrap;
            end else begin
                // Halted, disabled or invalid: accumulator holds, outputs idle
                r_ce  <= 1'b0;
                r_clk <= 1'b0;
            end
        end
    end

    assign ce_o  = r_ce;
    assign clk_o = r_clk;

endmodule
`default_nettype wire

// File: rtl/mf_clkgen_multi.sv
`default_nettype none
// ============================================================================
// Module      : mf_clkgen_multi
// Description : NUM_CH-channel fractional clock-enable generator running at
//               refclk*num/den per channel, with shadowed configuration,
//               synchronous re-alignment on apply/run rise, and a lock flag.
// Ports       : refclk, rst_n      - clock, async active-low reset
//               run                - level enable for all channels
//               cfg_we/ch/addr/wdata - shadow register write
//               cfg_apply          - shadow -> active, re-align all channels
//               ce_o[NUM_CH]       - per-channel enable pulses
//               clk_o[NUM_CH]      - per-channel square waves
//               locked             - all enabled channels stable
// Revision    : 1.0 - initial release
// ============================================================================
module mf_clkgen_multi
    import mf_clkgen_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ACC_W    = 32,
    parameter int LOCK_CYC = 16,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_addr,
    input  logic [ACC_W-1:0]  cfg_wdata,
    input  logic              cfg_apply,
    output logic [NUM_CH-1:0] ce_o,
    output logic [NUM_CH-1:0] clk_o,
    output logic              locked
);

    localparam int LK_W = $clog2(LOCK_CYC + 1);

    logic              r_run_d;
    logic [LK_W-1:0]   r_lock_cnt;
    logic              w_run_rise;
    logic              w_lock_clr;
    logic [NUM_CH-1:0] w_invalid;

    assign w_run_rise = run && !r_run_d;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            ch_cfg_t r_shadow;

            // Channel indices at or above NUM_CH never match, so such
            // writes fall away. A write coinciding with apply lands here
            // only; the channel copies the pre-write value at the same edge.
            always_ff @(posedge refclk or negedge rst_n) begin
                if (!rst_n) begin
                    r_shadow <= '0;
                end else if (cfg_we && (cfg_ch == CH_W'(i))) begin
                    r_shadow <= cfg_update(r_shadow, cfg_addr,
                                           CLKGEN_MAX_W'(cfg_wdata));
                end
            end

            mf_clkgen_ch #(
                .ACC_W (ACC_W)
            ) u_ch (
                .refclk     (refclk),
                .rst_n      (rst_n),
                .apply      (cfg_apply),
                .run_rise   (w_run_rise),
                .run        (run),
                .shadow_cfg (r_shadow),
                .ce_o       (ce_o[i]),
                .clk_o      (clk_o[i]),
                .invalid    (w_invalid[i])
            );
        end
    endgenerate

    // Run rise re-aligns the channels exactly like apply, so stability is
    // counted from that edge as well.
    assign w_lock_clr = cfg_apply || !run || w_run_rise || (|w_invalid);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_d    <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            r_run_d <= run;
            if (w_lock_clr) begin
                r_lock_cnt <= '0;
            end else if (r_lock_cnt != LK_W'(LOCK_CYC)) begin
                r_lock_cnt <= r_lock_cnt + LK_W'(1);
            end
        end
    end

    assign locked = (r_lock_cnt == LK_W'(LOCK_CYC));

endmodule
`default_nettype wire

// File: tb/tb_mf_clkgen_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_mf_clkgen_multi
// Description : Directed self-checking bench for mf_clkgen_multi (2 channels,
//               32-bit accumulators, 16-cycle lock).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mf_clkgen_multi;
    import mf_clkgen_pkg::*;

    logic        refclk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        cfg_we;
    logic        cfg_ch;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_apply;
    logic [1:0]  ce_o;
    logic [1:0]  clk_o;
    logic        locked;

    int vectors     = 0;
    int miscompares = 0;

    mf_clkgen_multi #(
        .NUM_CH   (2),
        .ACC_W    (32),
        .LOCK_CYC (16)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .run       (run),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_apply (cfg_apply),
        .ce_o      (ce_o),
        .clk_o     (clk_o),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic ch, input logic [1:0] addr, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_addr  = addr;
        cfg_wdata = data;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic do_apply();
        cfg_apply = 1'b1;
        step();
        cfg_apply = 1'b0;
    endtask

    initial begin
        int hits[9] = '{3, 6, 8, 11, 14, 16, 19, 22, 24};
        logic exp_ce;

        rst_n = 1'b0; run = 1'b0; cfg_we = 1'b0; cfg_ch = 1'b0;
        cfg_addr = 2'd0; cfg_wdata = '0; cfg_apply = 1'b0;

        // ---- reset state ----
        step(); step();
        check("rst_ce", 32'(ce_o), 32'd0);
        check("rst_clk", 32'(clk_o), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        rst_n = 1'b1;

        // ---- channels disabled until first apply ----
        run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("noapply_ce", 32'(ce_o), 32'd0);
        end
        run = 1'b0;
        step();

        // ---- A: ch0 1/4 phase 0; ce at 4,8,12,16, clk period 8, lock at 16 ----
        cfg_write(1'b0, CFG_NUM, 32'd1);
        cfg_write(1'b0, CFG_DEN, 32'd4);
        cfg_write(1'b0, CFG_PHASE, 32'd0);
        do_apply();
        run = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            step();
            check("A_ce0", 32'(ce_o[0]), 32'((k > 0) && (k % 4 == 0)));
            check("A_clk0", 32'(clk_o[0]), 32'((k / 4) % 2 == 1));
            check("A_ce1", 32'(ce_o[1]), 32'd0);
            check("A_locked", 32'(locked), 32'(k >= 16));
        end

        // ---- run low: outputs idle, lock dropped ----
        run = 1'b0;
        step();
        check("halt_ce", 32'(ce_o), 32'd0);
        check("halt_clk", 32'(clk_o), 32'd0);
        check("halt_locked", 32'(locked), 32'd0);

        // ---- B: ch1 1/4 phase 2 leads ch0 by 2 cycles; reserved addr ignored ----
        cfg_write(1'b1, CFG_NUM, 32'd1);
        cfg_write(1'b1, CFG_DEN, 32'd4);
        cfg_write(1'b1, CFG_PHASE, 32'd2);
        cfg_write(1'b1, 2'd3, 32'd1);
        do_apply();
        run = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            step();
            check("B_ce0", 32'(ce_o[0]), 32'((k > 0) && (k % 4 == 0)));
            check("B_ce1", 32'(ce_o[1]), 32'(k % 4 == 2));
            check("B_clk1", 32'(clk_o[1]), 32'(((k + 2) / 4) % 2 == 1));
        end

        // ---- C: ch0 3/8 (3 pulses per 8), ch1 phase>=den starts at 0 ----
        run = 1'b0;
        step();
        cfg_write(1'b0, CFG_NUM, 32'd3);
        cfg_write(1'b0, CFG_DEN, 32'd8);
        cfg_write(1'b1, CFG_PHASE, 32'd7);
        do_apply();
        run = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            step();
            exp_ce = 1'b0;
            for (int h = 0; h < 9; h++) if (hits[h] == k) exp_ce = 1'b1;
            check("C_ce0", 32'(ce_o[0]), 32'(exp_ce));
            check("C_ce1", 32'(ce_o[1]), 32'((k > 0) && (k % 4 == 0)));
            check("C_locked", 32'(locked), 32'(k >= 16));
        end

        // ---- re-apply while running, with a same-cycle write of num=1 ----
        cfg_we = 1'b1; cfg_ch = 1'b0; cfg_addr = CFG_NUM; cfg_wdata = 32'd1;
        cfg_apply = 1'b1;
        step();
        cfg_we = 1'b0; cfg_apply = 1'b0;
        check("reapply_locked", 32'(locked), 32'd0);
        check("reapply_ce0", 32'(ce_o[0]), 32'd0);
        check("reapply_clk", 32'(clk_o), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            // pre-write num=3 is active, so the first wrap is 3 cycles out
            check("wa_ce0", 32'(ce_o[0]), 32'(k == 3));
        end
        do_apply();
        for (int k = 1; k <= 8; k++) begin
            step();
            check("num1_ce0", 32'(ce_o[0]), 32'(k == 8));
        end

        // ---- D: ch1 5/4 invalid holds lock low; disabling it restores lock ----
        run = 1'b0;
        step();
        cfg_write(1'b1, CFG_NUM, 32'd5);
        cfg_write(1'b1, CFG_DEN, 32'd4);
        do_apply();
        run = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check("D_ce1", 32'(ce_o[1]), 32'd0);
            check("D_clk1", 32'(clk_o[1]), 32'd0);
            check("D_locked", 32'(locked), 32'd0);
        end
        cfg_write(1'b1, CFG_DEN, 32'd0);
        cfg_apply = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            step();
            cfg_apply = 1'b0;
            check("D2_locked", 32'(locked), 32'(k >= 16));
            check("D2_ce0", 32'(ce_o[0]), 32'((k == 8) || (k == 16)));
            check("D2_ce1", 32'(ce_o[1]), 32'd0);
        end

        // ---- asynchronous reset mid-run ----
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ce", 32'(ce_o), 32'd0);
        check("arst_clk", 32'(clk_o), 32'd0);
        check("arst_locked", 32'(locked), 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("postrst_ce", 32'(ce_o), 32'd0);
            check("postrst_clk", 32'(clk_o), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mf_clkgen_multi.md
MF_CLKGEN_MULTI -- requirements
Module: mf_clkgen_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of generated clock channels, range 1..8.
REQ-002 SHALL have parameter ACC_W, default 32: width of the numerator, denominator, phase and accumulator.
REQ-003 SHALL have parameter LOCK_CYC, default 16: refclk cycles of stable running before locked asserts.
REQ-004 Port refclk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port run, input, 1: level; 1 = channels generate, 0 = channels halted.
REQ-007 Port cfg_we, input, 1: shadow-register write strobe.
REQ-008 Port cfg_ch, input, $clog2(NUM_CH) (min 1): target channel of the write.
REQ-009 Port cfg_addr, input, 2: register select; 0 = num, 1 = den, 2 = phase, 3 = reserved (write ignored).
REQ-010 Port cfg_wdata, input, ACC_W: write data.
REQ-011 Port cfg_apply, input, 1: one-cycle pulse; copies all shadow registers to active and re-aligns all channels.
REQ-012 Port ce_o, output, NUM_CH: per-channel one-cycle clock-enable pulse at rate refclk*num/den.
REQ-013 Port clk_o, output, NUM_CH: per-channel square wave; toggles on each ce_o pulse.
REQ-014 Port locked, output, 1: all enabled channels valid and running stably.

Function
REQ-015 Channel with active den==0 SHALL be disabled: ce_o=0, clk_o=0, ignored by lock.
REQ-016 Channel with den!=0 and (num==0 or num>=den) SHALL be invalid: ce_o=0, clk_o=0, locked held 0.
REQ-017 Writes with cfg_ch>=NUM_CH or cfg_addr==3 SHALL be ignored.
REQ-018 cfg_we and cfg_apply in the same cycle: apply SHALL copy the pre-write shadow; the write lands in shadow only.
REQ-019 On apply, and on run 0->1, every channel's acc SHALL load phase if phase<den, else 0; clk_o SHALL clear to 0; ce_o=0 that cycle.
REQ-020 While run=1 and channel valid: each cycle sum=acc+num, computed ACC_W+1 bits wide; if sum>=den then acc<=sum-den and ce_o=1 next cycle, else acc<=sum.
REQ-021 ce_o SHALL be registered: exactly one cycle after the wrapping update.
REQ-022 clk_o SHALL toggle in the same cycle that ce_o is 1.
REQ-023 While run=0: acc held, ce_o=0, clk_o=0.
REQ-024 Lock counter SHALL clear on apply, on run=0, or if any enabled channel is invalid; otherwise increment, saturating at LOCK_CYC.
REQ-025 locked SHALL be 1 iff counter==LOCK_CYC, and SHALL drop the cycle after a clearing event.
REQ-026 Channels SHALL be mutually phase-aligned after apply: equal num/den with phase difference p gives a ce offset of p/num cycles when exact.

Reset
REQ-027 rst_n low SHALL immediately clear shadow and active num/den/phase, acc, ce_o, clk_o, the lock counter and locked to 0.
REQ-028 After reset release, all channels SHALL be disabled until a cfg_apply.

Structure
REQ-029 Shared package mf_clkgen_pkg SHALL hold the cfg_addr constants (CFG_NUM=0, CFG_DEN=1, CFG_PHASE=2) and the per-channel config struct.
REQ-030 Sub-module mf_clkgen_ch SHALL implement one channel (active regs, accumulator, ce/clk, valid/enabled flags), instantiated NUM_CH times; top holds shadow regs and lock.

Verification
REQ-031 ch0 num=1 den=4 phase=0, apply, run=1 -> ce_o[0] in cycles 4, 8, 12 after run rise; clk_o[0] period 8 cycles.
REQ-032 ch0 1/4 phase=0, ch1 1/4 phase=2 -> ce_o[1] leads ce_o[0] by 2 cycles, steady.
REQ-033 ch0 num=3 den=8 -> exactly 3 ce_o pulses per any 8-cycle window after the first wrap; locked=1 at cycle 16 after run rise.
REQ-034 ch1 num=5 den=4 -> ce_o[1]=0 and locked stays 0; set den=0 and apply -> locked reaches 1 after 16 cycles.
REQ-035 Re-apply while running -> locked drops next cycle, accs reload to phase; rst_n low mid-run -> all outputs 0 asynchronously.
